operand_read_seq: RTL

Parametrised operand-read sequencer for the matrix datapath. It collects a run-time-selectable number of register operands (1..MAX_OPERANDS), then an opcode, then issues a one-cycle ALU enable and waits for ALU completion. It adds explicit valid strobes, per-wait timeouts, abort and error reporting. It sits between the keypad/command decoder and the register file read port / ALU.

---
 rtl/operand_read_seq_pkg.sv | 15 +
 rtl/seq_timeout_timer.sv | 38 +++
 rtl/operand_read_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/operand_read_seq_pkg.sv
// Shared types for the operand-read sequencer: FSM state encoding and the NOP opcode value.
package operand_read_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_REG  = 3'd1,
        S_WAIT_OP   = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    localparam int unsigned NOP_OPCODE = '0;

endpackage

// File: rtl/seq_timeout_timer.sv
// Wait-state watchdog: counts cycles while run is high, flags expiry on the cycle the
// count reaches limit (limit of zero disables it).
module seq_timeout_timer #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 run,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    // Saturate so a disabled timer parked in a long wait never wraps.
    always_comb begin
        count_d = count_q;
        if (clear || !run) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q is zero on the first wait cycle, so limit-1 marks the limit-th waited cycle.
    assign expired = run && (limit != '0) && (count_q == limit - 1'b1);

endmodule

// File: rtl/operand_read_seq.sv
// Operand-read sequencer: gathers 1..MAX_OPERANDS register numbers and an opcode,
// fires a one-cycle ALU enable, then waits for ALU completion with timeout/abort handling.
module operand_read_seq
    import operand_read_seq_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 3,
    parameter int unsigned OPCODE_W     = 3,
    parameter int unsigned MAX_OPERANDS = 4,
    parameter int unsigned TIMEOUT_W    = 8,
    localparam int unsigned CNT_W       = $clog2(MAX_OPERANDS) + 1,
    localparam int unsigned IDX_W       = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r_en,
    input  logic [CNT_W-1:0]      num_operands,
    input  logic [TIMEOUT_W-1:0]  timeout_limit,
    input  logic                  reg_valid,
    input  logic [REG_ADDR_W-1:0] reg_num,
    input  logic                  op_valid,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  alu_done,
    input  logic                  abort,
    output logic [REG_ADDR_W-1:0] reg_sel,
    output logic [IDX_W-1:0]      opnd_idx,
    output logic                  rd_strobe,
    output logic                  alu_en,
    output logic [OPCODE_W-1:0]   opcode_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      num_q, num_d;
    logic [TIMEOUT_W-1:0]  limit_q, limit_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [REG_ADDR_W-1:0] reg_sel_q, reg_sel_d;
    logic [IDX_W-1:0]      opnd_idx_q, opnd_idx_d;
    logic [OPCODE_W-1:0]   opcode_out_q, opcode_out_d;
    logic                  rd_strobe_q, rd_strobe_d;
    logic                  alu_en_q, alu_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic strobe_ack;
    logic tmr_run;
    logic tmr_clear;
    logic tmr_expired;
    logic num_legal;

    assign num_legal = (num_operands != '0) && (num_operands <= CNT_W'(MAX_OPERANDS));
    assign tmr_run   = (state_q == S_WAIT_REG) || (state_q == S_WAIT_OP) || (state_q == S_WAIT_DONE);
    assign tmr_clear = strobe_ack || (state_d != state_q);

    seq_timeout_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .run     (tmr_run),
        .limit   (limit_q),
        .expired (tmr_expired)
    );

    // Next-state and output decode; abort beats timeout, timeout beats any strobe.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        limit_d      = limit_q;
        idx_d        = idx_q;
        reg_sel_d    = reg_sel_q;
        opnd_idx_d   = opnd_idx_q;
        opcode_out_d = opcode_out_q;
        err_d        = err_q;
        rd_strobe_d  = 1'b0;
        alu_en_d     = 1'b0;
        done_d       = 1'b0;
        strobe_ack   = 1'b0;

        if ((state_q != S_IDLE) && abort) begin
            state_d = S_IDLE;
        end else if (tmr_expired) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (r_en) begin
                        num_d   = num_operands;
                        limit_d = timeout_limit;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        if (num_legal) begin
                            state_d = S_WAIT_REG;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end
                    end
                end
                S_WAIT_REG: begin
                    if (reg_valid) begin
                        reg_sel_d   = reg_num;
                        opnd_idx_d  = idx_q;
                        rd_strobe_d = 1'b1;
                        strobe_ack  = 1'b1;
                        if (CNT_W'(idx_q) == num_q - 1'b1) begin
                            state_d = S_WAIT_OP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                S_WAIT_OP: begin
                    if (op_valid && (opcode != OPCODE_W'(NOP_OPCODE))) begin
                        opcode_out_d = opcode;
                        strobe_ack   = 1'b1;
                        state_d      = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_en_d = 1'b1;
                    state_d  = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (alu_done) begin
                        done_d     = 1'b1;
                        strobe_ack = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (!r_en) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            limit_q      <= '0;
            idx_q        <= '0;
            reg_sel_q    <= '0;
            opnd_idx_q   <= '0;
            opcode_out_q <= '0;
            rd_strobe_q  <= 1'b0;
            alu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            limit_q      <= limit_d;
            idx_q        <= idx_d;
            reg_sel_q    <= reg_sel_d;
            opnd_idx_q   <= opnd_idx_d;
            opcode_out_q <= opcode_out_d;
            rd_strobe_q  <= rd_strobe_d;
            alu_en_q     <= alu_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign reg_sel    = reg_sel_q;
    assign opnd_idx   = opnd_idx_q;
    assign rd_strobe  = rd_strobe_q;
    assign alu_en     = alu_en_q;
    assign opcode_out = opcode_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
